priority_isr_controller: RTL and testbench
==========================================

PRIORITY_ISR_CONTROLLER -- requirements
Module: priority_isr_controller

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 8, number of interrupt levels; power of two, 2..32.
REQ-002 SHALL have parameter LVL_W, default $clog2(N_CHANNELS), width of level-number fields.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ack_valid  input  1  interrupt acknowledge strobe.
REQ-006 SHALL have port ack_level  input  LVL_W  level being acknowledged.
REQ-007 SHALL have port auto_eoi  input  1  auto-EOI mode: the acknowledge does not set an ISR bit.
REQ-008 SHALL have port eoi_cmd  input  2  end-of-interrupt command: 00 none, 01 non-specific, 10 specific, 11 rotate-on-non-specific.
REQ-009 SHALL have port eoi_level  input  LVL_W  target level for a specific EOI.
REQ-010 SHALL have port prio_load  input  1  loads the lowest-priority level from prio_value.
REQ-011 SHALL have port prio_value  input  LVL_W  new lowest-priority level.
REQ-012 SHALL have port special_mask  input  N_CHANNELS  levels excluded from priority resolution.
REQ-013 SHALL have port in_service_register  output  N_CHANNELS  registered ISR.
REQ-014 SHALL have port highest_level_in_service  output  N_CHANNELS  registered one-hot of the highest-priority unmasked ISR bit, or 0.
REQ-015 SHALL have port priority_rotate  output  LVL_W  registered current lowest-priority level.
REQ-016 SHALL have port eoi_done  output  1  one-cycle pulse when an EOI cleared a bit.
REQ-017 SHALL have port eoi_done_level  output  LVL_W  level cleared; valid when eoi_done is high.

Function
REQ-018 Priority order SHALL be: (priority_rotate+1) mod N highest, descending cyclically to priority_rotate lowest.
REQ-019 Non-specific EOI (01/11) SHALL clear the highest-priority ISR bit among bits not set in special_mask; if no such bit exists, no change and no eoi_done.
REQ-020 Specific EOI SHALL clear ISR[eoi_level] regardless of special_mask; eoi_done SHALL pulse only if that bit was set.
REQ-021 eoi_cmd 11 SHALL additionally load priority_rotate with the cleared level; with no bit cleared, priority_rotate SHALL be unchanged.
REQ-022 ack_valid with auto_eoi low SHALL set ISR[ack_level]; an already-set bit SHALL stay set; with auto_eoi high the ISR SHALL be unchanged.
REQ-023 On same-cycle ack and EOI, the EOI SHALL be evaluated on the pre-edge ISR, then the ack set applied; set wins on the same level.
REQ-024 prio_load SHALL take precedence over an eoi_cmd 11 rotate in the same cycle.
REQ-025 highest_level_in_service SHALL be computed from next-state ISR, special_mask and priority_rotate and registered, so it is coherent with in_service_register in the same cycle (1-cycle latency from inputs).
REQ-026 eoi_done/eoi_done_level SHALL be registered and asserted the cycle after the command edge, aligned with the updated ISR.
REQ-027 Out-of-range level inputs cannot occur, because N is a power of two; no wrap handling SHALL be needed beyond mod N.

Reset
REQ-028 On reset: in_service_register=0, highest_level_in_service=0, priority_rotate=N_CHANNELS-1 (level 0 highest), eoi_done=0, eoi_done_level=0.
REQ-029 Reset SHALL override all same-cycle commands; commands in flight at reset SHALL be discarded.

Configuration
REQ-030 Macro ISR_ROTATE_ON_EOI_EN defined: REQ-021 and REQ-024 behave as stated.
REQ-031 Macro undefined: eoi_cmd 11 SHALL act exactly as 01, and priority_rotate SHALL change only via prio_load or reset.

Structure
REQ-032 Shared package isr_pkg SHALL hold the eoi_cmd encodings (EOI_NONE, EOI_NONSPEC, EOI_SPEC, EOI_ROTATE) and the default channel count.
REQ-033 Sub-module isr_priority_resolver (combinational: mask, rotate right, isolate lowest set bit, rotate left, one-hot to level) SHALL be instantiated twice: once for the non-specific EOI target, once for highest_level_in_service.

Verification (N=8)
REQ-034 Reset, then ack levels 3, 5, 1 -> ISR=0x2A, highest=0x02.
REQ-035 ISR=0x2A, EOI 01 -> ISR=0x28, eoi_done=1 with level 1, highest=0x08.
REQ-036 ISR=0x28, special_mask=0x08, EOI 01 -> ISR=0x08, eoi_done level 5, highest=0x00.
REQ-037 With the macro on, ISR=0x90 and rot=7, EOI 11 -> ISR=0x80, rot=4, highest=0x80; ack 2 next -> highest stays 0x80.
REQ-038 Same-cycle ack 6 and specific EOI 6 with ISR=0x40 -> ISR=0x40, eoi_done=1; reset asserted mid-sequence -> all outputs at REQ-028 values next cycle.

Source files
------------

// File: rtl/isr_pkg.sv
// Shared encodings and defaults for the priority ISR controller.
package isr_pkg;

  localparam int N_CHANNELS_DEFAULT = 8;

  typedef enum logic [1:0] {
    EOI_NONE    = 2'b00,
    EOI_NONSPEC = 2'b01,
    EOI_SPEC    = 2'b10,
    EOI_ROTATE  = 2'b11
  } eoi_cmd_e;

endpackage

// File: rtl/isr_priority_resolver.sv
// Combinational rotating-priority resolver: the highest-priority level is rot+1,
// descending cyclically to rot itself.
module isr_priority_resolver
  import isr_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEFAULT,
  parameter int LVL_W      = $clog2(N_CHANNELS)
) (
  input  logic [N_CHANNELS-1:0] req,
  input  logic [N_CHANNELS-1:0] mask,
  input  logic [LVL_W-1:0]      rot,
  output logic [N_CHANNELS-1:0] onehot,
  output logic [LVL_W-1:0]      level,
  output logic                  found
);

  logic [LVL_W-1:0]        shift;
  logic [N_CHANNELS-1:0]   masked;
  logic [N_CHANNELS-1:0]   rotated;
  logic [N_CHANNELS-1:0]   iso;
  logic [2*N_CHANNELS-1:0] dbl_r;
  logic [2*N_CHANNELS-1:0] dbl_l;

  // Shift wraps mod N for free because N is a power of two.
  assign shift   = rot + LVL_W'(1);
  assign masked  = req & ~mask;
  assign dbl_r   = {masked, masked} >> shift;
  assign rotated = dbl_r[N_CHANNELS-1:0];
  assign iso     = rotated & (~rotated + N_CHANNELS'(1));
  assign dbl_l   = {iso, iso} << shift;
  assign onehot  = dbl_l[2*N_CHANNELS-1:N_CHANNELS];
  assign found   = |iso;

  always_comb begin
    level = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      if (onehot[i]) level = level | LVL_W'(i);
    end
  end

endmodule

// File: rtl/priority_isr_controller.sv
// In-service register with rotating priority, EOI handling and ack capture.
// Optional feature: define ISR_ROTATE_ON_EOI_EN to enable rotate-on-non-specific EOI.
module priority_isr_controller
  import isr_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEFAULT,
  parameter int LVL_W      = $clog2(N_CHANNELS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ack_valid,
  input  logic [LVL_W-1:0]      ack_level,
  input  logic                  auto_eoi,
  input  logic [1:0]            eoi_cmd,
  input  logic [LVL_W-1:0]      eoi_level,
  input  logic                  prio_load,
  input  logic [LVL_W-1:0]      prio_value,
  input  logic [N_CHANNELS-1:0] special_mask,
  output logic [N_CHANNELS-1:0] in_service_register,
  output logic [N_CHANNELS-1:0] highest_level_in_service,
  output logic [LVL_W-1:0]      priority_rotate,
  output logic                  eoi_done,
  output logic [LVL_W-1:0]      eoi_done_level
);

  logic [N_CHANNELS-1:0] isr_p1;
  logic [N_CHANNELS-1:0] hi_p1;
  logic [LVL_W-1:0]      rot_p1;
  logic                  vld_p1;
  logic [LVL_W-1:0]      done_lvl_p1;

  eoi_cmd_e              cmd;
  logic [N_CHANNELS-1:0] isr_next;
  logic [LVL_W-1:0]      rot_next;
  logic                  done_next;
  logic [LVL_W-1:0]      done_lvl_next;

  logic [N_CHANNELS-1:0] eoi_onehot;
  logic [LVL_W-1:0]      eoi_lvl;
  logic                  eoi_found;
  logic [N_CHANNELS-1:0] hi_next;
  logic [LVL_W-1:0]      hi_level_unused;
  logic                  hi_found;

  // Non-specific EOI target, resolved on the pre-edge ISR.
  isr_priority_resolver #(.N_CHANNELS(N_CHANNELS), .LVL_W(LVL_W)) u_eoi_res (
    .req    (isr_p1),
    .mask   (special_mask),
    .rot    (rot_p1),
    .onehot (eoi_onehot),
    .level  (eoi_lvl),
    .found  (eoi_found)
  );

  // Highest in-service level, resolved on next-state values so it lands with the ISR.
  isr_priority_resolver #(.N_CHANNELS(N_CHANNELS), .LVL_W(LVL_W)) u_hi_res (
    .req    (isr_next),
    .mask   (special_mask),
    .rot    (rot_next),
    .onehot (hi_next),
    .level  (hi_level_unused),
    .found  (hi_found)
  );

  always_comb begin
    cmd           = eoi_cmd_e'(eoi_cmd);
    isr_next      = isr_p1;
    rot_next      = rot_p1;
    done_next     = 1'b0;
    done_lvl_next = done_lvl_p1;
`ifndef ISR_ROTATE_ON_EOI_EN
    if (cmd == EOI_ROTATE) cmd = EOI_NONSPEC;
`endif
    case (cmd)
      EOI_NONSPEC, EOI_ROTATE: begin
        if (eoi_found) begin
          isr_next      = isr_p1 & ~eoi_onehot;
          done_next     = 1'b1;
          done_lvl_next = eoi_lvl;
        end
      end
      EOI_SPEC: begin
        if (isr_p1[eoi_level]) begin
          isr_next[eoi_level] = 1'b0;
          done_next           = 1'b1;
          done_lvl_next       = eoi_level;
        end
      end
      default: ;
    endcase
    // Ack is applied after the EOI so a same-level set wins.
    if (ack_valid && !auto_eoi) isr_next[ack_level] = 1'b1;
`ifdef ISR_ROTATE_ON_EOI_EN
    if (cmd == EOI_ROTATE && done_next) rot_next = done_lvl_next;
`endif
    if (prio_load) rot_next = prio_value;
  end

  // Stage p1: registered ISR state and outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      isr_p1      <= '0;
      hi_p1       <= '0;
      rot_p1      <= LVL_W'(N_CHANNELS - 1);
      vld_p1      <= 1'b0;
      done_lvl_p1 <= '0;
    end else begin
      isr_p1      <= isr_next;
      hi_p1       <= hi_found ? hi_next : '0;
      rot_p1      <= rot_next;
      vld_p1      <= done_next;
      done_lvl_p1 <= done_lvl_next;
    end
  end

  assign in_service_register      = isr_p1;
  assign highest_level_in_service = hi_p1;
  assign priority_rotate          = rot_p1;
  assign eoi_done                 = vld_p1;
  assign eoi_done_level           = done_lvl_p1;

endmodule

// File: tb/tb_priority_isr_controller.sv
// Directed and randomized bench for priority_isr_controller (N=8) against a level-scan model.
module tb_priority_isr_controller;

  localparam int N = 8;
  localparam int LW = 3;

`ifdef ISR_ROTATE_ON_EOI_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          ack_valid;
  logic [LW-1:0] ack_level;
  logic          auto_eoi;
  logic [1:0]    eoi_cmd;
  logic [LW-1:0] eoi_level;
  logic          prio_load;
  logic [LW-1:0] prio_value;
  logic [N-1:0]  special_mask;
  logic [N-1:0]  in_service_register;
  logic [N-1:0]  highest_level_in_service;
  logic [LW-1:0] priority_rotate;
  logic          eoi_done;
  logic [LW-1:0] eoi_done_level;

  int checks = 0;
  int errors = 0;

  bit [N-1:0] m_isr;
  bit [N-1:0] m_hi;
  int         m_rot;
  bit         m_done;
  int         m_dlvl;

  priority_isr_controller #(.N_CHANNELS(N), .LVL_W(LW)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .ack_valid                (ack_valid),
    .ack_level                (ack_level),
    .auto_eoi                 (auto_eoi),
    .eoi_cmd                  (eoi_cmd),
    .eoi_level                (eoi_level),
    .prio_load                (prio_load),
    .prio_value               (prio_value),
    .special_mask             (special_mask),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .eoi_done                 (eoi_done),
    .eoi_done_level           (eoi_done_level)
  );

  always #5 clock = ~clock;

  // Scan levels from rot+1 downward cyclically; -1 when nothing eligible.
  function automatic int top_level(bit [N-1:0] isr, bit [N-1:0] mask, int rot);
    for (int k = 1; k <= N; k++) begin
      int l;
      l = (rot + k) % N;
      if (isr[l] && !mask[l]) return l;
    end
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; ack_valid = 0; ack_level = 0; auto_eoi = 0; eoi_cmd = 0;
    eoi_level = 0; prio_load = 0; prio_value = 0;
  endtask

  task automatic model_update();
    int c, l;
    if (reset) begin
      m_isr = '0; m_rot = N - 1; m_done = 0; m_dlvl = 0; m_hi = '0;
      return;
    end
    c = eoi_cmd;
    if (!ROT_EN && c == 3) c = 1;
    m_done = 0;
    if (c == 1 || c == 3) begin
      l = top_level(m_isr, special_mask, m_rot);
      if (l >= 0) begin m_isr[l] = 0; m_done = 1; m_dlvl = l; end
    end else if (c == 2) begin
      if (m_isr[eoi_level]) begin m_isr[eoi_level] = 0; m_done = 1; m_dlvl = eoi_level; end
    end
    if (ack_valid && !auto_eoi) m_isr[ack_level] = 1;
    if (prio_load) m_rot = prio_value;
    else if (c == 3 && m_done) m_rot = m_dlvl;
    l = top_level(m_isr, special_mask, m_rot);
    m_hi = (l < 0) ? '0 : (N'(1) << l);
  endtask

  // One clock with the currently driven inputs, then compare against the model.
  task automatic step(string tag);
    model_update();
    @(posedge clock);
    #1;
    chk({tag, "_isr"}, 32'(in_service_register), 32'(m_isr));
    chk({tag, "_hi"}, 32'(highest_level_in_service), 32'(m_hi));
    chk({tag, "_rot"}, 32'(priority_rotate), 32'(m_rot));
    chk({tag, "_done"}, 32'(eoi_done), 32'(m_done));
    if (m_done) chk({tag, "_dlvl"}, 32'(eoi_done_level), 32'(m_dlvl));
    idle();
  endtask

  task automatic do_ack(int lvl, string tag);
    ack_valid = 1; ack_level = LW'(lvl);
    step(tag);
  endtask

  task automatic do_reset();
    reset = 1;
    step("rst");
  endtask

  initial begin
    idle();
    special_mask = '0;
    m_isr = '0; m_rot = N - 1; m_done = 0; m_dlvl = 0; m_hi = '0;
    #2;

    // Reset values
    reset = 1;
    step("rst0");
    chk("rst_isr", 32'(in_service_register), 32'h0);
    chk("rst_hi", 32'(highest_level_in_service), 32'h0);
    chk("rst_rot", 32'(priority_rotate), 32'd7);
    chk("rst_done", 32'(eoi_done), 32'h0);
    chk("rst_dlvl", 32'(eoi_done_level), 32'h0);

    // Ack 3, 5, 1
    do_ack(3, "a3");
    do_ack(5, "a5");
    do_ack(1, "a1");
    chk("ack_isr", 32'(in_service_register), 32'h2A);
    chk("ack_hi", 32'(highest_level_in_service), 32'h02);

    // Non-specific EOI
    eoi_cmd = 2'b01;
    step("ns1");
    chk("ns1_isr", 32'(in_service_register), 32'h28);
    chk("ns1_done", 32'(eoi_done), 32'h1);
    chk("ns1_lvl", 32'(eoi_done_level), 32'd1);
    chk("ns1_hi", 32'(highest_level_in_service), 32'h08);

    // Non-specific EOI skipping a masked level
    special_mask = 8'h08; eoi_cmd = 2'b01;
    step("ns2");
    chk("ns2_isr", 32'(in_service_register), 32'h08);
    chk("ns2_lvl", 32'(eoi_done_level), 32'd5);
    chk("ns2_hi", 32'(highest_level_in_service), 32'h00);

    // Non-specific EOI with nothing eligible
    eoi_cmd = 2'b01;
    step("ns3");
    chk("ns3_done", 32'(eoi_done), 32'h0);
    chk("ns3_isr", 32'(in_service_register), 32'h08);
    special_mask = '0;

    // Rotate-on-EOI
    do_reset();
    do_ack(4, "a4");
    do_ack(7, "a7");
    eoi_cmd = 2'b11;
    step("rot");
    chk("rot_isr", 32'(in_service_register), 32'h80);
    chk("rot_hi", 32'(highest_level_in_service), 32'h80);
`ifdef ISR_ROTATE_ON_EOI_EN
    chk("rot_rot", 32'(priority_rotate), 32'd4);
    do_ack(2, "rot_a2");
    chk("rot_a2_hi", 32'(highest_level_in_service), 32'h80);
`else
    chk("rot_rot", 32'(priority_rotate), 32'd7);
    do_ack(2, "rot_a2");
    chk("rot_a2_hi", 32'(highest_level_in_service), 32'h04);
`endif

    // prio_load beats the rotate
    eoi_cmd = 2'b11; prio_load = 1; prio_value = 3'd2;
    step("pl");
    chk("pl_rot", 32'(priority_rotate), 32'd2);

    // Same-cycle ack and specific EOI on one level
    do_reset();
    do_ack(6, "a6");
    ack_valid = 1; ack_level = 3'd6; eoi_cmd = 2'b10; eoi_level = 3'd6;
    step("same");
    chk("same_isr", 32'(in_service_register), 32'h40);
    chk("same_done", 32'(eoi_done), 32'h1);
    chk("same_lvl", 32'(eoi_done_level), 32'd6);

    // Reset overrides commands in flight
    do_ack(2, "a2b");
    reset = 1; ack_valid = 1; ack_level = 3'd5; eoi_cmd = 2'b11; prio_load = 1; prio_value = 3'd1;
    step("rstcmd");
    chk("rstcmd_isr", 32'(in_service_register), 32'h0);
    chk("rstcmd_hi", 32'(highest_level_in_service), 32'h0);
    chk("rstcmd_rot", 32'(priority_rotate), 32'd7);
    chk("rstcmd_done", 32'(eoi_done), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 99) < 2);
      ack_valid    = $urandom_range(0, 1);
      ack_level    = LW'($urandom);
      auto_eoi     = ($urandom_range(0, 3) == 0);
      eoi_cmd      = 2'($urandom);
      eoi_level    = LW'($urandom);
      prio_load    = ($urandom_range(0, 9) == 0);
      prio_value   = LW'($urandom);
      special_mask = N'($urandom & $urandom);
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
